// File: rtl/memory_access_stage.sv
// MEM stage and MEM/WB pipeline register: loads/stores over a req/ack data-memory handshake.
// Optional macro MEM_TIMEOUT_EN adds a WAIT watchdog that aborts the access and sets a sticky err_out.
module memory_access_stage #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              wbs_in,
  input  logic              wme_in,
  input  logic              mm_in,
  input  logic [DATA_W-1:0] ALUresult_in,
  input  logic [DATA_W-1:0] memData_in,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              valid_out,
  output logic              wbs_out,
  output logic              mm_out,
  output logic [DATA_W-1:0] ALUresult_out,
  output logic [DATA_W-1:0] readData_out,
  output logic              err_out
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state, state_next;
  logic   mem_op;
  logic   held_wbs;
  logic   timeout_hit;

  assign mem_op = valid_in & (wme_in | mm_in);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // Counter sits at zero in IDLE, so it restarts on every entry to WAIT.
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst)                          err_q <= 1'b0;
    else if (timeout_hit && !mem_ack) err_q <= 1'b1;
  end

  assign err_out = err_q;
`else
  // Watchdog absent: WAIT lasts until mem_ack; TIMEOUT only shapes the optional build.
  assign timeout_hit = (TIMEOUT < 0);
  assign err_out     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_op) begin
          stall      = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = ~mem_ack & ~timeout_hit;
        if (mem_ack || timeout_hit) state_next = S_IDLE;
      end
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      held_wbs      <= 1'b0;
      valid_out     <= 1'b0;
      wbs_out       <= 1'b0;
      mm_out        <= 1'b0;
      ALUresult_out <= '0;
      readData_out  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_op) begin
            mem_req   <= 1'b1;
            mem_we    <= wme_in;
            mem_addr  <= ALUresult_in;
            mem_wdata <= memData_in;
            held_wbs  <= wbs_in;
            valid_out <= 1'b0;
          end else begin
            valid_out     <= valid_in;
            wbs_out       <= wbs_in;
            mm_out        <= mm_in & ~wme_in;
            ALUresult_out <= ALUresult_in;
            readData_out  <= '0;
          end
        end
        S_WAIT: begin
          if (mem_ack || timeout_hit) begin
            // mem_addr doubles as the latched ALU result; a store (mem_we) never forwards mm.
            mem_req       <= 1'b0;
            valid_out     <= 1'b1;
            wbs_out       <= held_wbs & mem_ack;
            mm_out        <= ~mem_we;
            ALUresult_out <= mem_addr;
            readData_out  <= (mem_ack && !mem_we) ? mem_rdata : '0;
          end else begin
            valid_out <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: scoreboard of expected MEM/WB records
// plus cycle-level checks of stall and the memory request interface.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, wbs_in, wme_in, mm_in;
  logic [15:0] ALUresult_in, memData_in;
  logic        stall, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        valid_out, wbs_out, mm_out, err_out;
  logic [15:0] ALUresult_out, readData_out;

  always #5 clk = ~clk;

  memory_access_stage #(.DATA_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .wbs_in(wbs_in), .wme_in(wme_in), .mm_in(mm_in),
    .ALUresult_in(ALUresult_in), .memData_in(memData_in),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .valid_out(valid_out), .wbs_out(wbs_out), .mm_out(mm_out),
    .ALUresult_out(ALUresult_out), .readData_out(readData_out), .err_out(err_out)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [33:0] sb[$];
  logic [33:0] exp_wb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every MEM/WB output is popped from the scoreboard in order.
  always @(negedge clk) begin
    if (rst === 1'b0 && valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 64'(valid_out), 64'(0));
      end else begin
        exp_wb = sb.pop_front();
        check("wb_record", {30'b0, wbs_out, mm_out, ALUresult_out, readData_out}, {30'b0, exp_wb});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic wbs, input logic wme, input logic mm,
                       input logic [15:0] alu, input logic [15:0] wd);
    valid_in = v; wbs_in = wbs; wme_in = wme; mm_in = mm;
    ALUresult_in = alu; memData_in = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_stall", 64'(stall), 64'(0));
      check("idle_req", 64'(mem_req), 64'(0));
      next_cycle();
    end
  endtask

  task automatic alu_op(input logic wbs, input logic [15:0] alu);
    drive(1'b1, wbs, 1'b0, 1'b0, alu, 16'h0);
    sb.push_back({wbs, 1'b0, alu, 16'h0000});
    @(negedge clk);
    check("alu_stall", 64'(stall), 64'(0));
    check("alu_req", 64'(mem_req), 64'(0));
    next_cycle();
  endtask

  // Issues a memory op and acks it in WAIT cycle number ack_at (1 = first WAIT cycle).
  task automatic mem_access(input logic wme, input logic mm, input logic wbs,
                            input logic [15:0] alu, input logic [15:0] wd,
                            input logic [15:0] rd, input int ack_at);
    drive(1'b1, wbs, wme, mm, alu, wd);
    sb.push_back({wbs, mm & ~wme, alu, wme ? 16'h0000 : rd});
    @(negedge clk);
    check("mem_issue_stall", 64'(stall), 64'(1));
    check("mem_issue_req", 64'(mem_req), 64'(0));
    for (int k = 1; k <= ack_at; k++) begin
      next_cycle();
      if (k == ack_at) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end
      @(negedge clk);
      check("wait_req", 64'(mem_req), 64'(1));
      check("wait_we", 64'(mem_we), 64'(wme));
      check("wait_addr", 64'(mem_addr), 64'(alu));
      check("wait_wdata", 64'(mem_wdata), 64'(wd));
      check("wait_stall", 64'(stall), (k == ack_at) ? 64'(0) : 64'(1));
      check("wait_bubble", 64'(valid_out), 64'(0));
    end
    next_cycle();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 16'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) next_cycle();
    @(negedge clk);
    check("reset_ctrl", {57'b0, stall, mem_req, mem_we, valid_out, wbs_out, mm_out, err_out}, 64'(0));
    check("reset_data", {mem_addr, mem_wdata, ALUresult_out, readData_out}, 64'(0));
    next_cycle();
    rst = 1'b0;

    // Plain ALU op, one-cycle latency.
    alu_op(1'b1, 16'h1234);
    idle_cycles(1);

    // Load acked in the third WAIT cycle.
    mem_access(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 16'hBEEF, 3);
    idle_cycles(1);

    // Store acked in the first WAIT cycle; read data must not leak through.
    mem_access(1'b1, 1'b0, 1'b0, 16'h4A81, 16'h7755, 16'hFFFF, 1);
    idle_cycles(1);

    // wme and mm both set: treated as a store, mm forwarded as 0.
    mem_access(1'b1, 1'b1, 1'b1, 16'h0022, 16'h0099, 16'hFFFF, 2);
    idle_cycles(1);

    // Back-to-back: load then ALU op on the edge that completes the load.
    mem_access(1'b0, 1'b1, 1'b1, 16'h0100, 16'h0000, 16'h1357, 2);
    alu_op(1'b1, 16'h00AA);
    idle_cycles(2);

    // Reset in the second WAIT cycle, late ack afterwards.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0300, 16'h0000);
    @(negedge clk);
    check("rstw_stall", 64'(stall), 64'(1));
    next_cycle();
    next_cycle();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check("rstw_req_pre", 64'(mem_req), 64'(1));
    next_cycle();
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    @(negedge clk);
    check("rstw_req", 64'(mem_req), 64'(0));
    check("rstw_stall_rel", 64'(stall), 64'(0));
    check("rstw_valid", 64'(valid_out), 64'(0));
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    check("rstw_late_ack", 64'(valid_out), 64'(0));
    next_cycle();
    idle_cycles(1);

`ifdef MEM_TIMEOUT_EN
    // Load with no ack: watchdog aborts after 4 WAIT cycles.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0555, 16'h0000);
    sb.push_back({1'b0, 1'b1, 16'h0555, 16'h0000});
    @(negedge clk);
    check("to_issue_stall", 64'(stall), 64'(1));
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      @(negedge clk);
      check("to_req", 64'(mem_req), 64'(1));
      check("to_stall", 64'(stall), (k == 4) ? 64'(0) : 64'(1));
      check("to_err_pre", 64'(err_out), 64'(0));
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check("to_req_drop", 64'(mem_req), 64'(0));
    check("to_valid", 64'(valid_out), 64'(1));
    check("to_err", 64'(err_out), 64'(1));
    next_cycle();
    alu_op(1'b1, 16'h0777);
    @(negedge clk);
    check("to_err_sticky", 64'(err_out), 64'(1));
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("to_err_clear", 64'(err_out), 64'(0));
    next_cycle();
`else
    @(negedge clk);
    check("err_tied", 64'(err_out), 64'(0));
    next_cycle();
`endif

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Memory (MEM) stage of the 16-bit pipeline.
- Consumes the execute/memory pipeline register outputs (wbs, wme, mm, ALUresult, memData) and runs loads/stores against a variable-latency data memory over a req/ack handshake.
- Stalls upstream while an access is outstanding.
- Registers results for the writeback stage, so it also acts as the MEM/WB pipeline register.

Parameters:
- DATA_W, 16, data/address width.
- TIMEOUT, 15, maximum WAIT cycles before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  EX/MEM slot holds a real instruction.
- wbs_in  input  1  register writeback enable.
- wme_in  input  1  memory write enable (store).
- mm_in  input  1  writeback takes memory data (load).
- ALUresult_in  input  DATA_W  ALU result / memory address.
- memData_in  input  DATA_W  store data.
- stall  output  1  hold upstream registers this cycle (combinational).
- mem_req  output  1  memory request (registered).
- mem_we  output  1  request is a write.
- mem_addr  output  DATA_W  request address.
- mem_wdata  output  DATA_W  write data.
- mem_rdata  input  DATA_W  read data, valid with mem_ack.
- mem_ack  input  1  one-cycle completion pulse.
- valid_out  output  1  MEM/WB slot valid.
- wbs_out  output  1  forwarded wbs.
- mm_out  output  1  forwarded mm.
- ALUresult_out  output  DATA_W  forwarded ALU result.
- readData_out  output  DATA_W  loaded data, 0 for non-loads.
- err_out  output  1  sticky access error.

Behaviour:
- Reset: state IDLE; stall, mem_req, mem_we, valid_out, wbs_out, mm_out, err_out = 0; mem_addr, mem_wdata, ALUresult_out, readData_out = 0.
- Memory op: valid_in & (wme_in | mm_in). If wme_in and mm_in are both set, the op is a store and mm_out is forwarded as 0.
- IDLE, no memory op: next edge loads the outputs from the inputs, with valid_out = valid_in and readData_out = 0. Latency is 1 cycle; stall = 0.
- IDLE, memory op:
  - stall = 1 in the same cycle.
  - Next edge: latch op fields; mem_req = 1, mem_we = wme_in, mem_addr = ALUresult_in, mem_wdata = memData_in; state goes to WAIT; valid_out = 0 (bubble).
- WAIT:
  - Inputs are ignored; upstream is held by stall.
  - mem_req, mem_we, mem_addr and mem_wdata stay stable.
  - stall = ~mem_ack. valid_out = 0 each edge without ack.
- WAIT with mem_ack:
  - Next edge: mem_req = 0, state goes to IDLE, valid_out = 1, latched wbs/mm/ALUresult are driven.
  - readData_out = mem_rdata for a load, 0 for a store.
  - stall = 0 in the ack cycle, so upstream advances on the same edge with no lost or duplicated instruction.
- mem_ack while mem_req = 0: ignored.
- Minimum load/store occupancy: 2 cycles (ack in the first WAIT cycle).
- rst asserted in any state, including mid-WAIT: the outstanding op is discarded, mem_req drops at that edge, and a late mem_ack after reset is ignored.
- err_out: cleared only by rst.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter (width $clog2(TIMEOUT+1)) resets on entry to WAIT.
  - After TIMEOUT WAIT cycles without ack, in the final WAIT cycle: stall = 0, and that edge drops mem_req and returns to IDLE.
  - The same edge sets valid_out = 1 with wbs_out = 0 (writeback suppressed), readData_out = 0, and err_out = 1 (sticky).
  - An ack in the final cycle wins over the timeout.
- Undefined: no counter; WAIT lasts until mem_ack indefinitely; err_out tied to 0.

Test Plan:
- ALU op: valid_in=1, wbs_in=1, mm_in=0, wme_in=0, ALUresult_in=16'h1234 -> next cycle valid_out=1, wbs_out=1, ALUresult_out=16'h1234, readData_out=0; mem_req and stall never asserted.
- Load: mm_in=1, wbs_in=1, ALUresult_in=16'h0040 presented at cycle 0; mem_ack with mem_rdata=16'hBEEF at cycle 3:
  - stall=1 in cycles 0-2, 0 in cycle 3.
  - mem_req=1, mem_we=0, mem_addr=16'h0040 in cycles 1-3.
  - Cycle 4: valid_out=1, mm_out=1, readData_out=16'hBEEF.
- Store: wme_in=1, ALUresult_in=16'h4A81, memData_in=16'h7755; ack in the first WAIT cycle -> mem_we=1, mem_addr=16'h4A81, mem_wdata=16'h7755 for 1 cycle; then valid_out=1, readData_out=0.
- Back-to-back: load (ack after 2 WAIT cycles) followed by ALU op 16'h00AA -> WB sequence is load result, then 16'h00AA one cycle later; bubbles only during WAIT; no duplicates.
- Reset mid-WAIT: rst in the 2nd WAIT cycle, mem_ack pulsed the cycle after -> after the reset edge mem_req=0, stall=0, valid_out=0; the late ack produces no output.
- With MEM_TIMEOUT_EN and TIMEOUT=4: load with no ack -> mem_req high exactly 4 cycles, stall released in the 4th WAIT cycle; next edge valid_out=1, wbs_out=0, readData_out=0, err_out=1 and it stays 1 until rst.
